// File: rtl/clock_pkg.sv
// Shared constants, field encoding and field-rotation helper for the time keeper.
package clock_pkg;

  localparam int unsigned PRESCALE_MAX = 999;
  localparam logic [3:0]  SEP_CODE     = 4'hA;
  localparam int unsigned HOUR_MAX     = 23;
  localparam int unsigned MINSEC_MAX   = 59;

  typedef enum logic [1:0] {
    FIELD_HOUR = 2'd0,
    FIELD_MIN  = 2'd1,
    FIELD_SEC  = 2'd2
  } field_e;

  // Field selection order while setting the time: hour -> min -> sec -> hour.
  function automatic field_e next_field(input field_e f);
    case (f)
      FIELD_HOUR: next_field = FIELD_MIN;
      FIELD_MIN:  next_field = FIELD_SEC;
      default:    next_field = FIELD_HOUR;
    endcase
  endfunction

endpackage

// File: rtl/time_keeper_if.sv
// Control keys and display-side outputs of the time keeper, grouped for benches and parents.
interface time_keeper_if;
  logic        adjust;
  logic        key_sel;
  logic        key_inc;
  logic [31:0] display_time;
  logic [7:0]  index;
  logic [1:0]  adj_field;
  logic        second_pulse;

  modport master (
    output adjust, key_sel, key_inc,
    input  display_time, index, adj_field, second_pulse
  );

  modport slave (
    input  adjust, key_sel, key_inc,
    output display_time, index, adj_field, second_pulse
  );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter 00..MAX_VAL, wrapping to 00; carry is high when an increment wraps.
module bcd_mod_counter #(
  parameter int unsigned MAX_VAL = 59
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_inc,
  output logic       o_carry,
  output logic [7:0] o_value
);

  localparam logic [3:0] MAX_TENS  = 4'(MAX_VAL / 10);
  localparam logic [3:0] MAX_UNITS = 4'(MAX_VAL % 10);

  logic [3:0] r_tens;
  logic [3:0] r_units;
  logic       w_at_max;

  assign w_at_max = (r_tens == MAX_TENS) && (r_units == MAX_UNITS);
  assign o_carry  = i_inc & w_at_max;
  assign o_value  = {r_tens, r_units};

  // Advance one BCD step per increment request, wrapping at the field limit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tens  <= '0;
      r_units <= '0;
    end else if (i_inc) begin
      if (w_at_max) begin
        r_tens  <= '0;
        r_units <= '0;
      end else if (r_units == 4'd9) begin
        r_tens  <= r_tens + 4'd1;
        r_units <= '0;
      end else begin
        r_units <= r_units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/time_keeper.sv
// 24-hour BCD clock on a 1 kHz clock, with key-driven time setting and a rotating digit scan.
module time_keeper
  import clock_pkg::*;
(
  input  logic        CP_1KHz,
  input  logic        CR,
  input  logic        adjust,
  input  logic        key_sel,
  input  logic        key_inc,
  output logic [31:0] display_time,
  output logic [7:0]  index,
  output logic [1:0]  adj_field,
  output logic        second_pulse
);

  logic [9:0] r_prescale;
  logic       r_sel_q;
  logic       r_inc_q;
  field_e     r_field;
  logic [7:0] r_index;
  logic       r_second_pulse;

  logic       w_tick;
  logic       w_sel_edge;
  logic       w_inc_edge;
  logic       w_sec_inc;
  logic       w_min_inc;
  logic       w_hour_inc;
  logic       w_sec_carry;
  logic       w_min_carry;
  logic       w_hour_carry_unused;
  logic [7:0] w_sec;
  logic [7:0] w_min;
  logic [7:0] w_hour;

  // Tick is gated by adjust so that entering set mode on the wrap cycle suppresses it.
  assign w_tick     = (r_prescale == 10'(PRESCALE_MAX)) & ~adjust;
  assign w_sel_edge = key_sel & ~r_sel_q & adjust;
  assign w_inc_edge = key_inc & ~r_inc_q & adjust;

  // Key increments touch only the selected field; carries propagate only on a run-mode tick.
  assign w_sec_inc  = w_tick | (w_inc_edge & (r_field == FIELD_SEC));
  assign w_min_inc  = (w_sec_carry & w_tick) | (w_inc_edge & (r_field == FIELD_MIN));
  assign w_hour_inc = (w_min_carry & w_tick) | (w_inc_edge & (r_field == FIELD_HOUR));

  bcd_mod_counter #(.MAX_VAL(MINSEC_MAX)) u_sec (
    .i_clk   (CP_1KHz),
    .i_rst   (CR),
    .i_inc   (w_sec_inc),
    .o_carry (w_sec_carry),
    .o_value (w_sec)
  );

  bcd_mod_counter #(.MAX_VAL(MINSEC_MAX)) u_min (
    .i_clk   (CP_1KHz),
    .i_rst   (CR),
    .i_inc   (w_min_inc),
    .o_carry (w_min_carry),
    .o_value (w_min)
  );

  bcd_mod_counter #(.MAX_VAL(HOUR_MAX)) u_hour (
    .i_clk   (CP_1KHz),
    .i_rst   (CR),
    .i_inc   (w_hour_inc),
    .o_carry (w_hour_carry_unused),
    .o_value (w_hour)
  );

  // Prescaler free-runs 0..999 in run mode and is parked at 0 while setting the time.
  always_ff @(posedge CP_1KHz or posedge CR) begin
    if (CR)                                     r_prescale <= '0;
    else if (adjust)                            r_prescale <= '0;
    else if (r_prescale == 10'(PRESCALE_MAX))   r_prescale <= '0;
    else                                        r_prescale <= r_prescale + 10'd1;
  end

  // Key history for edge detection, field selection, scan rotation and the second strobe.
  always_ff @(posedge CP_1KHz or posedge CR) begin
    if (CR) begin
      r_sel_q        <= 1'b0;
      r_inc_q        <= 1'b0;
      r_field        <= FIELD_HOUR;
      r_index        <= 8'h01;
      r_second_pulse <= 1'b0;
    end else begin
      r_sel_q        <= key_sel;
      r_inc_q        <= key_inc;
      r_index        <= {r_index[6:0], r_index[7]};
      r_second_pulse <= w_tick;
      if (!adjust)         r_field <= FIELD_HOUR;
      else if (w_sel_edge) r_field <= next_field(r_field);
    end
  end

  assign display_time = {w_hour, SEP_CODE, w_min, SEP_CODE, w_sec};
  assign index        = r_index;
  assign adj_field    = r_field;
  assign second_pulse = r_second_pulse;

endmodule
